// File: rtl/arb_fifo_pkg.sv
// Shared definitions for the arbiter output FIFO.
//   ARB_DATA_WIDTH        : word width of the arbiter stream (shared with arbiter/core)
//   ARB_FIFO_DEPTH_BITS   : default log2 of the FIFO capacity
//   ARB_FIFO_NEAR_FULL    : default NEAR_FULL threshold
//   ARB_LOST_W            : width of the lost-word counter
//   lost_sat_inc()        : saturating increment for the lost-word counter
package arb_fifo_pkg;

  localparam int ARB_DATA_WIDTH      = 32;
  localparam int ARB_FIFO_DEPTH_BITS = 13;
  localparam int ARB_FIFO_NEAR_FULL  = 6144;
  localparam int ARB_LOST_W          = 8;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ARB_LOST_W-1:0] lost_sat_inc(input logic [ARB_LOST_W-1:0] cnt);
    logic [ARB_LOST_W-1:0] one;
    one = ARB_LOST_W'(1);
    return (&cnt) ? cnt : cnt + one;
  endfunction

endpackage

// File: rtl/arb_fifo_ram.sv
// Simple dual-port RAM for the arbiter output FIFO.
//   clk_i   : clock
//   rst_i   : async active-high reset, clears only the read-data register
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates only when set
//   raddr_i : read address
//   rdata_o : registered read data (holds when re_i is low)
// The array itself carries no reset so it maps onto block RAM.
module arb_fifo_ram
  import arb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int ADDR_BITS  = ARB_FIFO_DEPTH_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_BITS-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arb_out_fifo.sv
// First-word-fall-through buffer between the readout arbiter and the host
// transfer logic.
//   BUS_CLK, BUS_RST     : clock, async active-high reset
//   CLEAR                : synchronous flush (wins over read and write)
//   WRITE_IN, DATA_IN    : arbiter write strobe and data
//   READY_OUT            : write is accepted when high (registered, = ~FULL)
//   FULL, NEAR_FULL      : registered level flags
//   READ                 : pop the head word
//   EMPTY, DATA_OUT      : head word, valid while EMPTY is low
//   SIZE                 : words held (write stage + RAM + output register)
//   LOST_COUNT           : writes refused while full, saturating
// Data path: write stage register -> RAM -> RAM read register (= DATA_OUT).
// A word accepted at edge N is written to RAM at N+1 and fetched at N+2.
module arb_out_fifo
  import arb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = ARB_DATA_WIDTH,
  parameter int DEPTH_BITS          = ARB_FIFO_DEPTH_BITS,
  parameter int NEAR_FULL_THRESHOLD = ARB_FIFO_NEAR_FULL
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  CLEAR,
  input  logic                  WRITE_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  READY_OUT,
  output logic                  FULL,
  output logic                  NEAR_FULL,
  input  logic                  READ,
  output logic                  EMPTY,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [DEPTH_BITS:0]   SIZE,
  output logic [ARB_LOST_W-1:0] LOST_COUNT
);

  localparam logic [DEPTH_BITS:0]   CAPACITY = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   NF_THR   = (DEPTH_BITS+1)'(NEAR_FULL_THRESHOLD);
  localparam logic [DEPTH_BITS:0]   SIZE_ONE = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic                  ready_q, full_q, near_full_q;
  logic                  full_d, near_full_d;
  logic                  out_vld_q, out_vld_d;
  logic                  wst_vld_q, wst_vld_d;
  logic [DATA_WIDTH-1:0] wst_data_q;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   size_q, size_d;
  logic [ARB_LOST_W-1:0] lost_q, lost_d;

  logic wr_acc, rd_acc, ram_we, ram_re, ram_nonempty;

  always_comb begin
    wr_acc       = WRITE_IN && ready_q && !CLEAR;
    rd_acc       = READ && out_vld_q && !CLEAR;
    ram_we       = wst_vld_q && !CLEAR;
    // The RAM never holds a full 2**DEPTH_BITS words (one always sits in the
    // output register at capacity), so equal pointers always mean empty.
    ram_nonempty = (wr_ptr_q != rd_ptr_q);
    // Fetch whenever the output register is free or being popped this cycle;
    // this both refills after a read and prefetches into an idle output.
    ram_re       = !CLEAR && ram_nonempty && (!out_vld_q || rd_acc);

    wst_vld_d   = wr_acc;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_vld_d   = out_vld_q;
    size_d      = size_q;
    lost_d      = lost_q;

    if (CLEAR) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      out_vld_d = 1'b0;
      size_d    = '0;
      lost_d    = '0;
    end else begin
      if (ram_we) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (ram_re) rd_ptr_d = rd_ptr_q + PTR_ONE;

      if (ram_re)      out_vld_d = 1'b1;
      else if (rd_acc) out_vld_d = 1'b0;

      if (wr_acc && !rd_acc)      size_d = size_q + SIZE_ONE;
      else if (!wr_acc && rd_acc) size_d = size_q - SIZE_ONE;

      // Refusals only count once out of reset: READY_OUT is low during the
      // release cycle while FULL is not, so FULL is the qualifier.
      if (WRITE_IN && full_q) lost_d = lost_sat_inc(lost_q);
    end

    full_d      = (size_d == CAPACITY);
    near_full_d = (size_d >= NF_THR);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      ready_q     <= 1'b0;
      full_q      <= 1'b0;
      near_full_q <= 1'b0;
      out_vld_q   <= 1'b0;
      wst_vld_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      size_q      <= '0;
      lost_q      <= '0;
    end else begin
      ready_q     <= !full_d;
      full_q      <= full_d;
      near_full_q <= near_full_d;
      out_vld_q   <= out_vld_d;
      wst_vld_q   <= wst_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      size_q      <= size_d;
      lost_q      <= lost_d;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (wr_acc) begin
      wst_data_q <= DATA_IN;
    end
  end

  arb_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (DEPTH_BITS)
  ) u_ram (
    .clk_i   (BUS_CLK),
    .rst_i   (BUS_RST),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wst_data_q),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (DATA_OUT)
  );

  assign READY_OUT  = ready_q;
  assign FULL       = full_q;
  assign NEAR_FULL  = near_full_q;
  assign EMPTY      = !out_vld_q;
  assign SIZE       = size_q;
  assign LOST_COUNT = lost_q;

endmodule

// File: doc/arb_out_fifo.md
Name: arb_out_fifo

Overview:
Single-clock 32-bit word buffer directly downstream of the readout core's round-robin arbiter. It accepts the arbiter word stream (write strobe, data, ready) and returns FULL/NEAR_FULL, which the core uses as trigger veto and backpressure. It presents a first-word-fall-through read port to the host transfer logic, and exposes fill level and a lost-word counter for monitoring.

Parameters:
DATA_WIDTH, 32, word width; must match the arbiter output.
DEPTH_BITS, 13, total capacity = 2**DEPTH_BITS words, output register included.
NEAR_FULL_THRESHOLD, 6144, NEAR_FULL asserts when SIZE >= this value.

Ports:
BUS_CLK  in  1  single clock for everything.
BUS_RST  in  1  asynchronous, active-high reset.
CLEAR  in  1  synchronous flush, one-cycle pulse.
WRITE_IN  in  1  write strobe from arbiter (ARB_WRITE_OUT).
DATA_IN  in  DATA_WIDTH  write data (ARB_DATA_OUT).
READY_OUT  out  1  write accepted when high (to ARB_READY_OUT).
FULL  out  1  SIZE == 2**DEPTH_BITS.
NEAR_FULL  out  1  SIZE >= NEAR_FULL_THRESHOLD.
READ  in  1  pop the current DATA_OUT word.
EMPTY  out  1  no valid word on DATA_OUT.
DATA_OUT  out  DATA_WIDTH  head word; valid while EMPTY = 0.
SIZE  out  DEPTH_BITS+1  words held: RAM plus output register.
LOST_COUNT  out  8  writes refused while full; saturates at 255.

Behaviour:
- Reset (async assert, sync release): READY_OUT=0 while BUS_RST is high, 1 from the first edge after release. EMPTY=1, FULL=0, NEAR_FULL=0, SIZE=0, DATA_OUT=0, LOST_COUNT=0, pointers=0.
- Write accepted at an edge when WRITE_IN && READY_OUT. READY_OUT = ~FULL, where FULL is a register. No combinational path from READ to READY_OUT.
- Read accepted at an edge when READ && ~EMPTY. READ while EMPTY is ignored and has no side effects.
- FWFT latency: a word written at edge N into an empty FIFO is on DATA_OUT with EMPTY=0 after edge N+2.
  - N+1: RAM write.
  - N+2: registered RAM read loads the output register.
- After a read, the next word shows on DATA_OUT after the next edge if the RAM holds data. Back-to-back reads sustain 1 word/cycle.
- Ordering: strict FIFO, no duplication, no loss of accepted words.
- SIZE update each edge: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. FULL and NEAR_FULL are registered from the next SIZE value, so they update on the same edge as SIZE.
- Full with simultaneous READ and WRITE_IN: the read completes and the write is refused (READY_OUT already low). LOST_COUNT increments. FULL drops the next cycle.
- Empty-with-pending: while the output register is empty and RAM holds data, a prefetch runs automatically with no READ needed.
- Pointers are DEPTH_BITS wide and wrap modulo 2**DEPTH_BITS. The RAM holds 2**DEPTH_BITS - 1 words plus one in the output register.
- LOST_COUNT: +1 per cycle with WRITE_IN && ~READY_OUT (including cycles in reset release? no: only after reset). Holds at 255.
- CLEAR (takes priority over read and write that cycle):
  - after the edge: pointers=0, SIZE=0, EMPTY=1, FULL=0, NEAR_FULL=0, LOST_COUNT=0, DATA_OUT holds its last value;
  - a same-cycle write is discarded and not counted lost;
  - any RAM read in flight is squashed.
- Reset mid-operation: all state returns to reset values immediately. RAM contents are don't-care.

Decomposition:
- Shared package arb_fifo_pkg:
  - ARB_DATA_WIDTH = 32, shared with the arbiter and core;
  - default DEPTH_BITS;
  - lost-counter width 8.
- One sub-module, arb_fifo_ram:
  - simple dual-port, one write port, one registered read port with read enable;
  - inferable as block RAM, no reset on the array.
- Pointer, count and output-register logic stays in arb_out_fifo.

Test Plan:
- Reset, then write 0xDEADBEEF at edge N with READ=0 -> EMPTY falls and DATA_OUT=0xDEADBEEF after edge N+2. SIZE=1, READY_OUT=1.
- Write 0..8191 continuously, then hold WRITE_IN for 3 more cycles -> FULL=1 and READY_OUT=0 after the 8192nd write. NEAR_FULL rose at SIZE=6144. LOST_COUNT=3.
- Starting full, READ and WRITE_IN together for 1 cycle -> word 0 popped and write refused. SIZE=8191, LOST_COUNT +1, FULL=0 next cycle.
- Stream 10000 incrementing words with READ held high and random WRITE_IN -> DATA_OUT sequence is exactly 0..9999, no gaps, SIZE returns to 0.
- Simultaneous accepted read and write at SIZE=5 -> SIZE stays 5 and DATA_OUT advances to the next word.
- Fill 100 words, assert CLEAR together with WRITE_IN -> next cycle SIZE=0, EMPTY=1, LOST_COUNT=0. The following write appears on DATA_OUT at N+2.
